seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits scanned (2..8).
REQ-002 SHALL have parameter DWELL, default 50000: cycles each digit is lit (>=1).
REQ-003 SHALL have parameter GUARD, default 2: all-anodes-off cycles before each digit (>=1).
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  scan enable; 0 turns display dark.
REQ-007 SHALL have port wr_valid  input  1  new frame offered.
REQ-008 SHALL have port wr_ready  output  1  frame buffer can accept.
REQ-009 SHALL have port wr_data  input  4*NUM_DIGITS  nibble i = digit i value.
REQ-010 SHALL have port wr_blank  input  NUM_DIGITS  bit i = 1 forces digit i dark.
REQ-011 SHALL have port dec_bcd  output  4  nibble presented to the shared external hex decoder.
REQ-012 SHALL have port dec_seg  input  7  combinational decoder result for dec_bcd (active-low segments, 0 = 7'b1000000).
REQ-013 SHALL have port seg_n  output  7  registered segment drive, active-low.
REQ-014 SHALL have port an_n  output  NUM_DIGITS  registered anode drive, active-low, one-hot-low or all ones.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-016 SHALL hold two frame registers: active (displayed) and pending (plus pending_full flag).
REQ-017 SHALL drive wr_ready = ~pending_full; a transfer occurs on a cycle with wr_valid & wr_ready, loading pending and setting pending_full next cycle.
REQ-018 SHALL implement states OFF, BLANK, SHOW with a digit pointer ptr (0..NUM_DIGITS-1) and one cycle counter cnt.
REQ-019 OFF: an_n all ones, seg_n = 7'h7F, ptr = 0; if pending_full, copy pending to active and clear pending_full next cycle; enable=1 -> BLANK, cnt=0.
REQ-020 BLANK: an_n all ones; dec_bcd = active nibble[ptr]; lasts exactly GUARD cycles; on its last cycle seg_n loads 7'h7F if active blank[ptr] else dec_seg; then -> SHOW, cnt=0.
REQ-021 SHOW: an_n[ptr] = 0, others 1, seg_n held; lasts exactly DWELL cycles; then ptr increments -> BLANK.
REQ-022 Wrap: on the last SHOW cycle with ptr = NUM_DIGITS-1, ptr -> 0, frame_done = 1 for that cycle, and if pending_full then active <- pending and pending_full clears in the same edge.
REQ-023 A transfer coinciding with the wrap edge while pending was empty SHALL NOT commit at that wrap; it commits at the next wrap.
REQ-024 Active frame SHALL change only at wrap or in OFF; no digit within a scan sees mixed frames.
REQ-025 enable=0 in any state SHALL force OFF at the next edge (an_n all ones, seg_n 7'h7F, ptr 0, cnt 0); pending contents are retained.
REQ-026 Per-digit period SHALL be GUARD+DWELL cycles; full scan NUM_DIGITS*(GUARD+DWELL) cycles.
REQ-027 dec_bcd SHALL equal active nibble[ptr] in every state (0 when in OFF with ptr 0 and active 0).
REQ-028 cnt width SHALL be clog2(max(DWELL,GUARD))+1; no arithmetic overflow at DWELL=1 or GUARD=1.

Reset
REQ-029 rst_n low SHALL asynchronously set: state OFF, ptr 0, cnt 0, active 0, active blank all ones, pending 0, pending_full 0, an_n all ones, seg_n 7'h7F, frame_done 0, wr_ready 1 after release.
REQ-030 Reset asserted mid-scan SHALL discard pending and active frames; display dark until re-enabled and re-written.

Verification (NUM_DIGITS=4, DWELL=4, GUARD=1)
REQ-031 Reset, write data 16'h3210 blank 0, enable -> an_n cycles 1110,1101,1011,0111 each 4 cycles with 1-cycle 1111 gaps; seg_n 7'b1000000,1111001,0100100,0110000.
REQ-032 Mid-scan write 16'hFFFF -> wr_ready drops next cycle; digits keep 3210 until frame_done, then all show 7'b0001110; wr_ready returns 1 after commit edge.
REQ-033 Write with wr_blank=4'b0101 -> digits 0 and 2 show seg_n 7'h7F while their anode is low; digits 1,3 decoded.
REQ-034 Deassert enable during SHOW of digit 2 -> next edge an_n 1111, seg_n 7'h7F; re-enable restarts at digit 0 after 1 guard cycle.
REQ-035 Write offered on exact wrap edge with pending empty -> frame_done pulses, old frame shown for one more full scan (20 cycles), new frame from following wrap.
REQ-036 Assert rst_n low during SHOW of digit 1 -> outputs dark immediately (asynchronous), wr_ready 1, pending_full 0 after release.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Multiplexed 7-segment display scanner with a double-buffered frame.
//   A frame (one nibble plus one blank bit per digit) is written into a
//   pending buffer. It moves to the active (displayed) buffer only while
//   the scanner is idle or at the end of a complete scan, so a scan never
//   mixes two frames. Each digit is preceded by GUARD all-anodes-off
//   cycles and then lit for DWELL cycles.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = scan, 0 = display dark (next edge)
//   wr_valid/wr_ready/wr_data/wr_blank : frame write handshake
//   dec_bcd     : nibble sent to the shared external hex decoder
//   dec_seg     : decoder result for dec_bcd (active-low segments)
//   seg_n       : registered segment drive, active-low
//   an_n        : registered anode drive, active-low, one digit at a time
//   frame_done  : one-cycle pulse on the last cycle of a full scan
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int GUARD      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [4*NUM_DIGITS-1:0]   wr_data,
  input  logic [NUM_DIGITS-1:0]     wr_blank,
  output logic [3:0]                dec_bcd,
  input  logic [6:0]                dec_seg,
  output logic [6:0]                seg_n,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_done
);

  localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int PW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_DARK   = 7'h7F;

  typedef enum logic [1:0] {
    S_OFF,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                    state;
  logic [PW-1:0]             ptr;
  logic [CW-1:0]             cnt;
  logic [4*NUM_DIGITS-1:0]   active_data;
  logic [NUM_DIGITS-1:0]     active_blank;
  logic [4*NUM_DIGITS-1:0]   pend_data;
  logic [NUM_DIGITS-1:0]     pend_blank;
  logic                      pend_full;

  logic                      cur_blank;
  logic                      wrap;
  logic                      take;
  logic                      commit;

  // Select the active digit addressed by ptr (nibble and blank flag).
  always_comb begin
    dec_bcd   = '0;
    cur_blank = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (ptr == PW'(i)) begin
        dec_bcd   = active_data[4*i +: 4];
        cur_blank = active_blank[i];
      end
    end
  end

  // A scan completes only if the scanner is still enabled on its last cycle.
  assign wrap       = (state == S_SHOW) && (cnt == DWELL_LAST) &&
                      (ptr == PTR_LAST) && enable;
  assign frame_done = wrap;
  assign wr_ready   = ~pend_full;
  assign take       = wr_valid & ~pend_full;
  // commit needs an already-full pending buffer, so a write accepted on the
  // wrap edge itself waits for the following wrap.
  assign commit     = pend_full & ((state == S_OFF) | wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_OFF;
      ptr          <= '0;
      cnt          <= '0;
      active_data  <= '0;
      active_blank <= '1;
      pend_data    <= '0;
      pend_blank   <= '0;
      pend_full    <= 1'b0;
      an_n         <= '1;
      seg_n        <= SEG_DARK;
    end else begin
      // Frame buffers: commit and accept are exclusive (full vs. empty).
      if (commit) begin
        active_data  <= pend_data;
        active_blank <= pend_blank;
        pend_full    <= 1'b0;
      end else if (take) begin
        pend_data    <= wr_data;
        pend_blank   <= wr_blank;
        pend_full    <= 1'b1;
      end

      if (!enable) begin
        state <= S_OFF;
        ptr   <= '0;
        cnt   <= '0;
        an_n  <= '1;
        seg_n <= SEG_DARK;
      end else begin
        case (state)
          S_OFF: begin
            state <= S_BLANK;
            ptr   <= '0;
            cnt   <= '0;
            an_n  <= '1;
            seg_n <= SEG_DARK;
          end
          S_BLANK: begin
            if (cnt == GUARD_LAST) begin
              seg_n <= cur_blank ? SEG_DARK : dec_seg;
              an_n  <= ~(NUM_DIGITS'(1) << ptr);
              state <= S_SHOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_SHOW: begin
            if (cnt == DWELL_LAST) begin
              an_n  <= '1;
              state <= S_BLANK;
              cnt   <= '0;
              ptr   <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= S_OFF;
            ptr   <= '0;
            cnt   <= '0;
            an_n  <= '1;
            seg_n <= SEG_DARK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=4, GUARD=1.
//   Digit period is 5 cycles (1 guard + 4 lit), full scan 20 cycles.
//   k counts cycles from the edge that samples enable=1: k%5==0 is the
//   guard cycle of digit (k/5)%4, and k%20==19 is the last cycle of a scan.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_blank;
  logic [3:0]  dec_bcd;
  logic [6:0]  dec_seg;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;
  int k;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .DWELL     (4),
    .GUARD     (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_blank  (wr_blank),
    .dec_bcd   (dec_bcd),
    .dec_seg   (dec_seg),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  // External hex decoder, active-low gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
      4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
      4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  always_comb dec_seg = hex7(dec_bcd);

  function automatic logic [3:0] exp_an(input int kk);
    if (kk % 5 == 0) return 4'hF;
    return ~(4'b0001 << ((kk / 5) % 4));
  endfunction

  function automatic logic [3:0] exp_nib(input int kk, input logic [15:0] d);
    return d[4*((kk / 5) % 4) +: 4];
  endfunction

  function automatic logic [6:0] exp_seg(input int kk, input logic [15:0] d,
                                         input logic [3:0] b);
    int dg;
    dg = (kk / 5) % 4;
    return b[dg] ? 7'h7F : hex7(d[4*dg +: 4]);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (an_n !== 4'hF) begin fails++; $display("FAIL reset_an got %b want 1111", an_n); end
    checks++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", seg_n); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_fd got %b want 0", frame_done); end
    checks++; if (dec_bcd !== 4'h0) begin fails++; $display("FAIL reset_bcd got %h want 0", dec_bcd); end
    #2 rst_n = 1'b1;
    step;
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL reset_rdy got %b want 1", wr_ready); end
  endtask

  task automatic test_basic_scan;
    wr_data = 16'h3210; wr_blank = 4'b0000; wr_valid = 1'b1;
    step;
    wr_valid = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL load_rdy got %b want 0", wr_ready); end
    step;
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL offcommit_rdy got %b want 1", wr_ready); end
    enable = 1'b1;
    k = -1;
    repeat (20) begin
      step; k++;
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL basic_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
      checks++; if (dec_bcd !== exp_nib(k, 16'h3210)) begin fails++; $display("FAIL basic_bcd k=%0d got %h want %h", k, dec_bcd, exp_nib(k, 16'h3210)); end
      if (k % 5 != 0) begin
        checks++; if (seg_n !== exp_seg(k, 16'h3210, 4'b0000)) begin fails++; $display("FAIL basic_seg k=%0d got %b want %b", k, seg_n, exp_seg(k, 16'h3210, 4'b0000)); end
      end
      checks++; if (frame_done !== (k % 20 == 19)) begin fails++; $display("FAIL basic_fd k=%0d got %b want %b", k, frame_done, (k % 20 == 19)); end
    end
  endtask

  task automatic test_pending_write;
    logic [15:0] fd;
    logic        er;
    repeat (40) begin
      if (k == 27) begin wr_data = 16'hFFFF; wr_blank = 4'b0000; wr_valid = 1'b1; end
      step; k++;
      wr_valid = 1'b0;
      fd = (k < 40) ? 16'h3210 : 16'hFFFF;
      er = !(k >= 28 && k <= 39);
      checks++; if (wr_ready !== er) begin fails++; $display("FAIL pend_rdy k=%0d got %b want %b", k, wr_ready, er); end
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL pend_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
      checks++; if (dec_bcd !== exp_nib(k, fd)) begin fails++; $display("FAIL pend_bcd k=%0d got %h want %h", k, dec_bcd, exp_nib(k, fd)); end
      if (k % 5 != 0) begin
        checks++; if (seg_n !== exp_seg(k, fd, 4'b0000)) begin fails++; $display("FAIL pend_seg k=%0d got %b want %b", k, seg_n, exp_seg(k, fd, 4'b0000)); end
      end
      checks++; if (frame_done !== (k % 20 == 19)) begin fails++; $display("FAIL pend_fd k=%0d got %b want %b", k, frame_done, (k % 20 == 19)); end
    end
  endtask

  task automatic test_wrap_write;
    logic [15:0] fd;
    logic        er;
    repeat (40) begin
      if (k == 59) begin wr_data = 16'h5678; wr_blank = 4'b0000; wr_valid = 1'b1; end
      step; k++;
      wr_valid = 1'b0;
      fd = (k < 80) ? 16'hFFFF : 16'h5678;
      er = !(k >= 60 && k <= 79);
      checks++; if (wr_ready !== er) begin fails++; $display("FAIL wrap_rdy k=%0d got %b want %b", k, wr_ready, er); end
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL wrap_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
      checks++; if (dec_bcd !== exp_nib(k, fd)) begin fails++; $display("FAIL wrap_bcd k=%0d got %h want %h", k, dec_bcd, exp_nib(k, fd)); end
      if (k % 5 != 0) begin
        checks++; if (seg_n !== exp_seg(k, fd, 4'b0000)) begin fails++; $display("FAIL wrap_seg k=%0d got %b want %b", k, seg_n, exp_seg(k, fd, 4'b0000)); end
      end
      checks++; if (frame_done !== (k % 20 == 19)) begin fails++; $display("FAIL wrap_fd k=%0d got %b want %b", k, frame_done, (k % 20 == 19)); end
    end
  endtask

  task automatic test_blank_mask;
    logic [15:0] fd;
    logic [3:0]  fb;
    logic        er;
    repeat (40) begin
      if (k == 99) begin wr_data = 16'h4321; wr_blank = 4'b0101; wr_valid = 1'b1; end
      step; k++;
      wr_valid = 1'b0;
      fd = (k < 120) ? 16'h5678 : 16'h4321;
      fb = (k < 120) ? 4'b0000 : 4'b0101;
      er = !(k >= 100 && k <= 119);
      checks++; if (wr_ready !== er) begin fails++; $display("FAIL blank_rdy k=%0d got %b want %b", k, wr_ready, er); end
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL blank_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
      checks++; if (dec_bcd !== exp_nib(k, fd)) begin fails++; $display("FAIL blank_bcd k=%0d got %h want %h", k, dec_bcd, exp_nib(k, fd)); end
      if (k % 5 != 0) begin
        checks++; if (seg_n !== exp_seg(k, fd, fb)) begin fails++; $display("FAIL blank_seg k=%0d got %b want %b", k, seg_n, exp_seg(k, fd, fb)); end
      end
      checks++; if (frame_done !== (k % 20 == 19)) begin fails++; $display("FAIL blank_fd k=%0d got %b want %b", k, frame_done, (k % 20 == 19)); end
    end
  endtask

  task automatic test_disable;
    logic er;
    // Pending frame ABCD is loaded mid-scan, then enable drops during digit 2.
    repeat (12) begin
      if (k == 144) begin wr_data = 16'hABCD; wr_blank = 4'b0000; wr_valid = 1'b1; end
      step; k++;
      wr_valid = 1'b0;
      er = (k < 145);
      checks++; if (wr_ready !== er) begin fails++; $display("FAIL dis_rdy k=%0d got %b want %b", k, wr_ready, er); end
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL dis_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
      if (k % 5 != 0) begin
        checks++; if (seg_n !== exp_seg(k, 16'h4321, 4'b0101)) begin fails++; $display("FAIL dis_seg k=%0d got %b want %b", k, seg_n, exp_seg(k, 16'h4321, 4'b0101)); end
      end
    end
    enable = 1'b0;
    step;
    checks++; if (an_n !== 4'hF) begin fails++; $display("FAIL off_an got %b want 1111", an_n); end
    checks++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL off_seg got %h want 7f", seg_n); end
    checks++; if (dec_bcd !== 4'h1) begin fails++; $display("FAIL off_bcd got %h want 1", dec_bcd); end
    checks++; if (wr_ready !== 1'b0) begin fails++; $display("FAIL off_rdy got %b want 0", wr_ready); end
    step;
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL off_commit_rdy got %b want 1", wr_ready); end
    checks++; if (dec_bcd !== 4'hD) begin fails++; $display("FAIL off_commit_bcd got %h want d", dec_bcd); end
    checks++; if (an_n !== 4'hF) begin fails++; $display("FAIL off_hold_an got %b want 1111", an_n); end
    enable = 1'b1;
    k = -1;
    repeat (10) begin
      step; k++;
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL reen_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
      if (k % 5 != 0) begin
        checks++; if (seg_n !== exp_seg(k, 16'hABCD, 4'b0000)) begin fails++; $display("FAIL reen_seg k=%0d got %b want %b", k, seg_n, exp_seg(k, 16'hABCD, 4'b0000)); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic er;
    repeat (17) begin
      if (k == 22) begin wr_data = 16'h1111; wr_blank = 4'b0000; wr_valid = 1'b1; end
      step; k++;
      wr_valid = 1'b0;
      er = (k < 23);
      checks++; if (wr_ready !== er) begin fails++; $display("FAIL rm_rdy k=%0d got %b want %b", k, wr_ready, er); end
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL rm_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
    end
    // k=26: digit 1 lit. Reset takes effect without a clock edge.
    rst_n = 1'b0;
    #1;
    checks++; if (an_n !== 4'hF) begin fails++; $display("FAIL async_an got %b want 1111", an_n); end
    checks++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL async_seg got %h want 7f", seg_n); end
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL async_rdy got %b want 1", wr_ready); end
    checks++; if (dec_bcd !== 4'h0) begin fails++; $display("FAIL async_bcd got %h want 0", dec_bcd); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL async_fd got %b want 0", frame_done); end
    enable = 1'b0;
    #1 rst_n = 1'b1;
    step;
    checks++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL post_rdy got %b want 1", wr_ready); end
    checks++; if (an_n !== 4'hF) begin fails++; $display("FAIL post_an got %b want 1111", an_n); end
    enable = 1'b1;
    k = -1;
    // Active frame was discarded: every digit is blanked.
    repeat (10) begin
      step; k++;
      checks++; if (an_n !== exp_an(k)) begin fails++; $display("FAIL dark_an k=%0d got %b want %b", k, an_n, exp_an(k)); end
      checks++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL dark_seg k=%0d got %b want 1111111", k, seg_n); end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_blank = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_basic_scan;
    test_pending_write;
    test_wrap_write;
    test_blank_mask;
    test_disable;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
